// File: rtl/bridge_i2c_buf_nbank.sv
// Bank-rotating bridge: routes img2col channel reads to the active IFM buffer bank
// and realigns returned data; bank switches wait for in-flight reads to drain.
module bridge_i2c_buf_nbank #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned ADDR_W   = 80,
  parameter int unsigned DATA_W   = 1024,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned NUM_BANK = 2,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned BW       = $clog2(NUM_BANK)
) (
  input  logic                                clock,
  input  logic                                rst_n,
  input  logic                                loop_end,
  input  logic                                buf_switch,
  input  logic [NUM_BANK-1:0]                 bank_ready,
  output logic [NUM_BANK-1:0]                 bank_release,
  output logic                                switch_done,
  output logic                                i2c_stall,
  output logic [BW-1:0]                       cur_bank,
  output logic [NUM_BANK*NUM_CH*SIZE-1:0]     ifm_rd_en,
  output logic [NUM_BANK*NUM_CH*ADDR_W-1:0]   ifm_rd_addr,
  input  logic [NUM_BANK*NUM_CH*DATA_W-1:0]   ifm_out,
  input  logic [NUM_CH*SIZE-1:0]              ifm_rd_en_i2c,
  input  logic [NUM_CH*ADDR_W-1:0]            ifm_rd_addr_i2c,
  output logic [NUM_CH*DATA_W-1:0]            pixel_2_i2c,
  output logic [NUM_CH-1:0]                   pixel_vld
);

  logic [BW-1:0]                    sel;
  logic [BW-1:0]                    sel_wrap;
  logic                             pend;
  logic [RD_LAT-1:0][NUM_CH-1:0]    en_pipe;
  logic [RD_LAT-1:0][BW-1:0]        sel_pipe;
  logic [NUM_CH-1:0]                fwd_any;
  logic [BW-1:0]                    sel_last;
  logic                             inflight;
  logic                             commit;

  assign cur_bank = sel;
  assign sel_last = sel_pipe[RD_LAT-1];
  assign sel_wrap = (sel == BW'(NUM_BANK - 1)) ? '0 : sel + BW'(1);

  // Stall, drain detection and switch commit
  always_comb begin
    i2c_stall = !rst_n || pend || !bank_ready[sel];
    inflight  = 1'b0;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
      inflight = inflight | (|en_pipe[i]);
    end
    commit       = rst_n && pend && !inflight && !loop_end;
    switch_done  = commit;
    bank_release = '0;
    if (rst_n && (commit || (loop_end && (sel != '0)))) begin
      bank_release[sel] = 1'b1;
    end
  end

  // Request routing: only the active bank sees enables and addresses
  always_comb begin
    fwd_any     = '0;
    ifm_rd_en   = '0;
    ifm_rd_addr = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      fwd_any[c] = !i2c_stall && (|ifm_rd_en_i2c[c*SIZE +: SIZE]);
    end
    if (rst_n) begin
      for (int b = 0; b < int'(NUM_BANK); b++) begin
        if (sel == BW'(b)) begin
          for (int c = 0; c < int'(NUM_CH); c++) begin
            ifm_rd_addr[(b*NUM_CH+c)*ADDR_W +: ADDR_W] = ifm_rd_addr_i2c[c*ADDR_W +: ADDR_W];
            if (!i2c_stall) begin
              ifm_rd_en[(b*NUM_CH+c)*SIZE +: SIZE] = ifm_rd_en_i2c[c*SIZE +: SIZE];
            end
          end
        end
      end
    end
  end

  // Return path: data taken from the bank that was active when the read issued
  always_comb begin
    pixel_2_i2c = '0;
    pixel_vld   = '0;
    if (rst_n) begin
      pixel_vld = en_pipe[RD_LAT-1];
      for (int b = 0; b < int'(NUM_BANK); b++) begin
        if (sel_last == BW'(b)) begin
          for (int c = 0; c < int'(NUM_CH); c++) begin
            pixel_2_i2c[c*DATA_W +: DATA_W] = ifm_out[(b*NUM_CH+c)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Bank pointer, pending switch and read-latency pipelines
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sel      <= '0;
      pend     <= 1'b0;
      en_pipe  <= '0;
      sel_pipe <= '0;
    end else begin
      en_pipe[0]  <= fwd_any;
      sel_pipe[0] <= sel;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        en_pipe[i]  <= en_pipe[i-1];
        sel_pipe[i] <= sel_pipe[i-1];
      end
      if (loop_end) begin
        sel  <= '0;
        pend <= 1'b0;
      end else if (commit) begin
        sel  <= sel_wrap;
        pend <= 1'b0;
      end else if (buf_switch) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/bridge_i2c_buf_nbank.md
# bridge_i2c_buf_nbank

Parametrised bank-rotating bridge between NUM_CH img2col read ports and NUM_BANK IFM buffer banks, each bank holding one read port per channel. It routes each channel's read enable and address to the active bank and returns read data through an RD_LAT-aligned select pipeline with a per-channel valid. Bank switches are a drained handshake: requests are stalled until in-flight reads return, then the bank pointer advances and the vacated bank is released to the loader. It sits between the IFM buffer array and the img2col units.

## Interface
- SIZE, 8: read-enable bits per channel port (byte-lane enables)
- ADDR_W, 80: address bits per channel port
- DATA_W, 1024: data bits per channel port
- NUM_CH, 2: img2col channels (≥1)
- NUM_BANK, 2: buffer banks (≥2)
- RD_LAT, 1: buffer read latency in cycles (≥1)
- BW, $clog2(NUM_BANK): bank-pointer width

Port slices below are flattened; slice index for bank b, channel c is k = b*NUM_CH+c.
- clock  in  1  sole clock, rising edge
- rst_n  in  1  synchronous active-low reset
- loop_end  in  1  end of layer loop; forces bank pointer to 0
- buf_switch  in  1  one-cycle request to advance to the next bank
- bank_ready  in  NUM_BANK  loader flag: bank b holds valid data
- bank_release  out  NUM_BANK  one-cycle pulse: bank b vacated, may be refilled
- switch_done  out  1  one-cycle pulse when a switch commits
- i2c_stall  out  1  img2col must hold its request; enables are masked
- cur_bank  out  BW  active bank pointer
- ifm_rd_en  out  NUM_BANK*NUM_CH*SIZE  per-bank, per-channel read enables
- ifm_rd_addr  out  NUM_BANK*NUM_CH*ADDR_W  per-bank, per-channel addresses
- ifm_out  in  NUM_BANK*NUM_CH*DATA_W  per-bank, per-channel read data
- ifm_rd_en_i2c  in  NUM_CH*SIZE  channel read enables
- ifm_rd_addr_i2c  in  NUM_CH*ADDR_W  channel addresses
- pixel_2_i2c  out  NUM_CH*DATA_W  returned data per channel
- pixel_vld  out  NUM_CH  returned data valid per channel

## Operation
- State: sel (BW bits), pend (1 bit), en_pipe (RD_LAT × NUM_CH bits), sel_pipe (RD_LAT × BW bits).
- i2c_stall = pend | !bank_ready[sel].
- Forwarded enable fwd_c = i2c_stall ? 0 : ifm_rd_en_i2c[c].
- Slice k for bank sel gets fwd_c and ifm_rd_addr_i2c[c]. Every other bank gets enable 0 and address 0 (combinational).
- en_pipe stage 0 takes |fwd_c; sel_pipe stage 0 takes sel. Both shift one stage per cycle.
- pixel_vld[c] = last en_pipe stage. pixel_2_i2c[c] = ifm_out slice (last sel_pipe stage, c), also driven while invalid.
- inflight = OR of all en_pipe stages except the last.
- Switch:
  - buf_switch=1 sets pend.
  - Commit occurs on the first cycle with pend=1 and inflight=0 (the request cycle itself never commits).
  - On commit: sel ← (sel+1) mod NUM_BANK (wrap from NUM_BANK-1 to 0); pend ← 0; switch_done=1 and bank_release[old sel]=1 for exactly that cycle.
- buf_switch while pend=1 is absorbed. No queueing, one switch only.
- loop_end has priority over everything:
  - sel ← 0, pend ← 0.
  - No switch_done.
  - bank_release[old sel]=1 only if old sel ≠ 0.
  - Pipelines continue so reads already in flight still return.
- bank_ready low on the current bank stalls reads only. It never blocks a pending switch from committing.

## Timing
- Reset (rst_n=0 at a rising edge): sel=0, pend=0, all pipes 0.
- All combinational outputs are forced to 0 while rst_n=0: switch_done, bank_release, pixel_vld, ifm_rd_en, ifm_rd_addr, pixel_2_i2c.
- i2c_stall is forced to 1 while rst_n=0.
- Read latency: enable at cycle t gives pixel_vld at t+RD_LAT, with data from the bank active at t.
- Switch latency with no reads in flight: buf_switch at t, commit at edge t+1, new cur_bank visible at t+2. Each in-flight read adds up to RD_LAT cycles.
- Reset mid-switch drops pend and all in-flight valids.

## Test plan
- Default params, bank_ready=2'b11: ch0 en=8'hFF addr=5 → ifm_rd_en slice k0 = FF, slice k2 = 0. One cycle later pixel_vld[0]=1 and data = bank0 ch0 value.
- RD_LAT=3, ch1 reads every cycle, buf_switch pulse: stall rises the next cycle; commit only after 2 drain cycles. All 3 trailing valids carry bank0 data. bank_release=2'b01, cur_bank=1.
- NUM_BANK=3: three switches → cur_bank sequence 1,2,0. Release pulses on banks 0,1,2 in order.
- buf_switch and loop_end in the same cycle with sel=1 → sel=0, no switch_done, bank_release=2'b10.
- bank_ready[1]=0 after switching to bank 1 → i2c_stall=1, no enables forwarded. Raise bank_ready → reads resume the same cycle.
- rst_n low with pend=1 and reads in flight → all outputs 0, stall=1. After release: cur_bank=0, no stray pixel_vld.
